servo_ramp_pwm: RTL and testbench

Servo output stage between the servo sequencing FSM and the servo pin. Accepts a commanded pulse width in microseconds and produces the 50 Hz servo PWM. The applied width slews toward the command by a bounded step per 20 ms frame, so arm and gripper moves are smooth instead of instantaneous. The applied width is clamped to a safe range and changes only at frame boundaries, so no pulse is ever truncated or stretched mid-frame.

---
 rtl/servo_ramp_pwm.sv | 169 ++++++++++++++++
 tb/tb_servo_ramp_pwm.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/servo_ramp_pwm.sv
// servo_ramp_pwm: 50 Hz servo PWM stage with a slew-limited, clamped pulse width.
// The applied width moves toward the commanded width by at most STEP_US per frame.
// It changes only at frame boundaries, so a pulse is never cut short or stretched.
module servo_ramp_pwm #(
  parameter int CLK_PER_US = 50,
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = 500,
  parameter int MAX_US     = 2500,
  parameter int STEP_US    = 20,
  parameter int INIT_US    = 1500
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic [20:0] target_us,
  input  logic        jump,
  output logic        pwm_signal,
  output logic [20:0] current_us,
  output logic        frame_start,
  output logic        settled
);

  // Width of the microsecond prescaler; kept at least one bit wide when CLK_PER_US is 1.
  localparam int              US_W       = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [US_W-1:0] US_LAST    = US_W'(CLK_PER_US - 1);
  localparam logic [US_W-1:0] US_ZERO    = US_W'(0);
  localparam logic [US_W-1:0] US_ONE     = US_W'(1);
  localparam logic [20:0]     FRAME_LAST = 21'(FRAME_US - 1);
  localparam logic [20:0]     MIN_W      = 21'(MIN_US);
  localparam logic [20:0]     MAX_W      = 21'(MAX_US);
  localparam logic [20:0]     STEP_W     = 21'(STEP_US);
  localparam logic [20:0]     INIT_W     = 21'(INIT_US);

  // Limit a commanded width to the mechanically safe range.
  function automatic logic [20:0] clamp_width(input logic [20:0] req);
    logic [20:0] res;
    if (req < MIN_W) begin
      res = MIN_W;
    end else if (req > MAX_W) begin
      res = MAX_W;
    end else begin
      res = req;
    end
    return res;
  endfunction

  // Move cur one bounded step toward tgt.
  // The comparison happens before any subtraction, so the unsigned differences never underflow.
  // The result never passes tgt.
  function automatic logic [20:0] step_toward(input logic [20:0] cur,
                                              input logic [20:0] tgt);
    logic [20:0] diff;
    logic [20:0] res;
    diff = 21'd0;
    if (tgt > cur) begin
      diff = tgt - cur;
      if (diff > STEP_W) begin
        res = cur + STEP_W;
      end else begin
        res = tgt;
      end
    end else if (tgt < cur) begin
      diff = cur - tgt;
      if (diff > STEP_W) begin
        res = cur - STEP_W;
      end else begin
        res = tgt;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  logic [US_W-1:0] us_cnt_r;
  logic [20:0]     frame_cnt_r;
  logic [20:0]     current_us_r;
  logic            pwm_r;
  logic            frame_start_r;
  logic            settled_r;

  logic            us_tick_s;
  logic            frame_end_s;
  logic [20:0]     tgt_c_s;
  logic [20:0]     next_us_s;

  // Decode the prescaler wrap and the last microsecond of the frame.
  always_comb begin
    us_tick_s   = 1'b0;
    frame_end_s = 1'b0;
    if (us_cnt_r == US_LAST) begin
      us_tick_s = 1'b1;
    end else begin
      us_tick_s = 1'b0;
    end
    if (us_tick_s && (frame_cnt_r == FRAME_LAST)) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
  end

  // Clamp the command and pick the width for the next frame.
  // A high jump level bypasses the ramp entirely.
  always_comb begin
    tgt_c_s   = clamp_width(target_us);
    next_us_s = current_us_r;
    if (jump) begin
      next_us_s = tgt_c_s;
    end else begin
      next_us_s = step_toward(current_us_r, tgt_c_s);
    end
  end

  // Microsecond prescaler: counts clock cycles within one microsecond.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt_r <= US_ZERO;
    end else if (us_tick_s) begin
      us_cnt_r <= US_ZERO;
    end else begin
      us_cnt_r <= us_cnt_r + US_ONE;
    end
  end

  // Frame counter: counts microseconds within one PWM frame.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 21'd0;
    end else if (frame_end_s) begin
      frame_cnt_r <= 21'd0;
    end else if (us_tick_s) begin
      frame_cnt_r <= frame_cnt_r + 21'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Applied width: target_us and jump are sampled only at the frame boundary.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      current_us_r <= INIT_W;
    end else if (frame_end_s) begin
      current_us_r <= next_us_s;
    end else begin
      current_us_r <= current_us_r;
    end
  end

  // Registered outputs: the PWM level, the frame start marker and the settled flag.
  // The PWM level is one cycle behind frame_cnt.
  // As a result, the frame_end edge produces a low level and the new width starts cleanly.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r         <= 1'b0;
      frame_start_r <= 1'b0;
      settled_r     <= 1'b0;
    end else begin
      pwm_r         <= (frame_cnt_r < current_us_r);
      frame_start_r <= frame_end_s;
      settled_r     <= (current_us_r == tgt_c_s);
    end
  end

  assign pwm_signal  = pwm_r;
  assign current_us  = current_us_r;
  assign frame_start = frame_start_r;
  assign settled     = settled_r;

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Testbench for servo_ramp_pwm.
// Scaled parameters keep each frame short; the width model works per frame with plain integer arithmetic.
`timescale 1ns/1ps
module tb_servo_ramp_pwm;

  localparam int CPU   = 2;
  localparam int FUS   = 60;
  localparam int MINU  = 10;
  localparam int MAXU  = 50;
  localparam int STEPU = 7;
  localparam int INITU = 25;
  localparam int F     = CPU * FUS;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [20:0] target_us;
  logic        jump;
  logic        pwm_signal;
  logic [20:0] current_us;
  logic        frame_start;
  logic        settled;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cur;

  always #5 clk = ~clk;

  servo_ramp_pwm #(
    .CLK_PER_US(CPU),
    .FRAME_US  (FUS),
    .MIN_US    (MINU),
    .MAX_US    (MAXU),
    .STEP_US   (STEPU),
    .INIT_US   (INITU)
  ) dut (
    .clk_50MHz  (clk),
    .rst_n      (rst_n),
    .target_us  (target_us),
    .jump       (jump),
    .pwm_signal (pwm_signal),
    .current_us (current_us),
    .frame_start(frame_start),
    .settled    (settled)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int t);
    if (t < MINU) return MINU;
    if (t > MAXU) return MAXU;
    return t;
  endfunction

  // Width for the next frame from the current width, the command and the jump flag.
  function automatic int next_w(input int cur, input int t, input bit j);
    int tc;
    int d;
    tc = clampi(t);
    if (j) return tc;
    d = tc - cur;
    if (d > STEPU) return cur + STEPU;
    if (d < -STEPU) return cur - STEPU;
    return tc;
  endfunction

  // Run one frame starting at a frame_start negedge, or just after reset release.
  // At cycle 'off', drive a new command and jump level.
  // Measure the high time and the period, then check the width applied at the next boundary.
  task automatic run_frame(input int t, input bit j, input int off);
    int hi  = 0;
    int cyc = 0;
    int mid_bad = 0;
    bit got = 1'b0;
    while (!got && cyc < 2 * F) begin
      @(negedge clk);
      cyc++;
      if (cyc == off) begin
        target_us = 21'(t);
        jump      = j;
      end
      if (cyc == F - 2) begin
        chk("settled", int'(settled), int'(model_cur == clampi(int'(target_us))));
      end
      if (frame_start) begin
        got = 1'b1;
      end else begin
        hi += int'(pwm_signal);
        if (int'(current_us) != model_cur) mid_bad = 1;
      end
    end
    chk("pulse_high", hi, model_cur * CPU);
    chk("period", cyc, F);
    chk("width_held", mid_bad, 0);
    model_cur = next_w(model_cur, int'(target_us), jump);
    chk("width_update", int'(current_us), model_cur);
  endtask

  function automatic int roff();
    return int'($urandom_range(1, F - 3));
  endfunction

  initial begin
    rst_n     = 1'b0;
    target_us = 21'(INITU);
    jump      = 1'b0;
    model_cur = INITU;

    repeat (10) @(negedge clk);
    chk("rst_pwm", int'(pwm_signal), 0);
    chk("rst_width", int'(current_us), INITU);
    chk("rst_fs", int'(frame_start), 0);
    chk("rst_settled", int'(settled), 0);
    rst_n = 1'b1;

    // First frame after reset, then a ramp up with a step that does not divide the distance
    run_frame(INITU, 1'b0, 5);
    for (int i = 0; i < 4; i++) run_frame(45, 1'b0, roff());
    run_frame(45, 1'b0, roff());

    // Clamp high, then clamp low without underflow
    for (int i = 0; i < 3; i++) run_frame(100, 1'b0, roff());
    for (int i = 0; i < 8; i++) run_frame(3, 1'b0, roff());

    // Jump bypasses the ramp; target equal to current holds the width
    run_frame(40, 1'b1, roff());
    run_frame(0, 1'b1, roff());
    run_frame(MINU, 1'b0, roff());
    run_frame(MINU, 1'b0, roff());

    // Randomized commands, jump levels and change points
    for (int i = 0; i < 40; i++) begin
      run_frame(int'($urandom_range(0, 70)), ($urandom_range(0, 3) == 0), roff());
    end

    // Reset asserted in the middle of a pulse
    repeat (5) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_signal), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pwm", int'(pwm_signal), 0);
    chk("midrst_width", int'(current_us), INITU);
    chk("midrst_fs", int'(frame_start), 0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    model_cur = INITU;
    run_frame(60, 1'b0, 3);
    run_frame(60, 1'b0, roff());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
